// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, data width, line idle level and parity helper.
// Used by both the transmit and receive paths.
package uart_pkg;

    localparam int unsigned DATA_W           = 8;
    localparam int unsigned CLKS_PER_BIT_DEF = 868;
    localparam logic        LINE_IDLE        = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Bit that makes the total number of ones even (odd = 0) or odd (odd = 1).
    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the bit boundary.
// pre_tick marks the cycle before the boundary so callers can register boundary-aligned pulses.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick,
    output logic pre_tick
);

    localparam int unsigned      CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE   = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap at the bit boundary while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick     = en & (cnt_q == LAST);
    assign pre_tick = en & (cnt_q == PRE);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit framing controller: byte handshake, start/data/parity/stop serialisation
// with registered outputs.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam logic       LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic [2:0] LAST_BIT  = 3'd7;

    uart_state_e       state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [2:0]        bit_idx_q;
    logic              stop_idx_q;
    logic              parity_q;
    logic              serial_q;
    logic              busy_q;
    logic              ready_q;
    logic              done_q;

    logic handshake_s;
    logic tick_s;
    logic pre_tick_s;

    assign handshake_s = tx_valid & ready_q;

    // Clearing on handshake makes the start bit exactly one full bit period long.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (handshake_s),
        .en      (busy_q),
        .tick    (tick_s),
        .pre_tick(pre_tick_s)
    );

    // Frame FSM with registered line, status and done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            parity_q   <= 1'b0;
            serial_q   <= LINE_IDLE;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    serial_q <= LINE_IDLE;
                    if (handshake_s) begin
                        shreg_q    <= tx_data;
                        parity_q   <= parity_bit(tx_data, PARITY_ODD);
                        bit_idx_q  <= 3'd0;
                        stop_idx_q <= 1'b0;
                        serial_q   <= 1'b0;
                        busy_q     <= 1'b1;
                        ready_q    <= 1'b0;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (tick_s) begin
                        serial_q <= shreg_q[0];
                        state_q  <= DATA;
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        if (bit_idx_q == LAST_BIT) begin
                            if (PARITY_EN) begin
                                serial_q <= parity_q;
                                state_q  <= PARITY;
                            end else begin
                                serial_q   <= LINE_IDLE;
                                stop_idx_q <= 1'b0;
                                state_q    <= STOP;
                            end
                        end else begin
                            // Next bit is shreg_q[1], which becomes bit 0 after the shift.
                            shreg_q   <= {1'b0, shreg_q[DATA_W-1:1]};
                            serial_q  <= shreg_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (tick_s) begin
                        serial_q   <= LINE_IDLE;
                        stop_idx_q <= 1'b0;
                        state_q    <= STOP;
                    end
                end
                STOP: begin
                    serial_q <= LINE_IDLE;
                    // Raise done one cycle early so the registered pulse lands in the last cycle.
                    if (pre_tick_s && (stop_idx_q == LAST_STOP)) begin
                        done_q <= 1'b1;
                    end
                    if (tick_s) begin
                        if (stop_idx_q == LAST_STOP) begin
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            stop_idx_q <= stop_idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    serial_q <= LINE_IDLE;
                    busy_q   <= 1'b0;
                    ready_q  <= 1'b1;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign tx_serial = serial_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;
    // Ready is withheld while reset is asserted so no byte is accepted during reset.
    assign tx_ready  = ready_q & ~rst;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: four parameterisations compared cycle by cycle
// against a bit-list frame model, plus table vectors, back-to-back, reset and random frames.
module tb_uart_tx_ctrl;

    localparam int unsigned C        = 4;
    localparam bit [3:0]    PEN_M    = 4'b0110;
    localparam bit [3:0]    ODD_M    = 4'b0100;
    localparam bit [3:0]    TWO_STOP = 4'b1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dat [4];
    logic [3:0] vld;
    logic [3:0] rdy;
    logic [3:0] ser;
    logic [3:0] bsy;
    logic [3:0] dn;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut_plain (
        .clk(clk), .rst(rst), .tx_data(dat[0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .tx_serial(ser[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));
    uart_tx_ctrl #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut_even (
        .clk(clk), .rst(rst), .tx_data(dat[1]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .tx_serial(ser[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));
    uart_tx_ctrl #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) dut_odd (
        .clk(clk), .rst(rst), .tx_data(dat[2]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .tx_serial(ser[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));
    uart_tx_ctrl #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) dut_stop2 (
        .clk(clk), .rst(rst), .tx_data(dat[3]), .tx_valid(vld[3]),
        .tx_ready(rdy[3]), .tx_serial(ser[3]), .tx_busy(bsy[3]), .tx_done(dn[3]));

    typedef struct {
        int         unit;
        logic [7:0] data;
        logic [7:0] mid;
        int         exp_len;
        logic       exp_par;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Starts at the negedge of the first frame cycle; returns at the negedge of the cycle after it.
    task automatic run_frame(input int u, input logic [7:0] b, input logic [7:0] mid,
                             input bit noise, input bit hold,
                             output int done_at, output logic par_seen);
        logic       bits [12];
        int         nb;
        int         ones;
        int         len;
        logic [3:0] exp_v;
        logic [3:0] got_v;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin bits[nb] = b[i]; nb++; end
        if (PEN_M[u]) begin
            bits[nb] = ODD_M[u] ? ((ones % 2) == 0) : ((ones % 2) == 1);
            nb++;
        end
        for (int s = 0; s < (TWO_STOP[u] ? 2 : 1); s++) begin bits[nb] = 1'b1; nb++; end
        len      = nb * C;
        done_at  = -1;
        par_seen = 1'b0;
        for (int k = 1; k <= len; k++) begin
            exp_v = {bits[(k-1)/C], 1'b1, 1'b0, (k == len)};
            got_v = {ser[u], bsy[u], rdy[u], dn[u]};
            chk($sformatf("u%0d byte 0x%02h cycle %0d {ser,busy,ready,done}", u, b, k),
                32'(got_v), 32'(exp_v));
            if (dn[u] && done_at < 0) done_at = k;
            if (PEN_M[u] && k == 9 * C + 2) par_seen = ser[u];
            if (k == 8) dat[u] = mid;
            if (noise) begin
                vld[u] = 1'($urandom);
                dat[u] = 8'($urandom);
            end
            if (k == len) vld[u] = hold;
            @(negedge clk);
        end
        chk($sformatf("u%0d idle after byte 0x%02h", u, b),
            32'({ser[u], bsy[u], rdy[u], dn[u]}), 32'(4'b1010));
    endtask

    task automatic send(input int u, input logic [7:0] b, input logic [7:0] mid, input bit noise,
                        output int done_at, output logic par_seen);
        chk($sformatf("u%0d ready before 0x%02h", u, b), 32'(rdy[u]), 32'd1);
        dat[u] = b;
        vld[u] = 1'b1;
        @(negedge clk);
        vld[u] = 1'b0;
        run_frame(u, b, mid, noise, 1'b0, done_at, par_seen);
    endtask

    initial begin
        int   done_at;
        logic par;
        int   bad;
        int   u;
        int   gap;
        logic [7:0] b;

        vt[0] = '{unit: 0, data: 8'h55, mid: 8'h55, exp_len: 40, exp_par: 1'b0};
        vt[1] = '{unit: 1, data: 8'hA3, mid: 8'h00, exp_len: 44, exp_par: 1'b0};
        vt[2] = '{unit: 1, data: 8'hA7, mid: 8'hFF, exp_len: 44, exp_par: 1'b1};
        vt[3] = '{unit: 2, data: 8'hA3, mid: 8'h5C, exp_len: 44, exp_par: 1'b1};
        vt[4] = '{unit: 3, data: 8'h80, mid: 8'h7F, exp_len: 44, exp_par: 1'b0};
        vt[5] = '{unit: 0, data: 8'h12, mid: 8'h34, exp_len: 40, exp_par: 1'b0};

        rst = 1'b1;
        vld = 4'b0000;
        for (int i = 0; i < 4; i++) dat[i] = 8'h00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk($sformatf("u%0d in reset", i), 32'({ser[i], bsy[i], rdy[i], dn[i]}), 32'(4'b1000));
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++)
            chk($sformatf("u%0d after reset", i), 32'({ser[i], bsy[i], rdy[i], dn[i]}), 32'(4'b1010));
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            send(vt[i].unit, vt[i].data, vt[i].mid, 1'b0, done_at, par);
            chk($sformatf("vec%0d done position", i), 32'(done_at), 32'(vt[i].exp_len));
            if (PEN_M[vt[i].unit])
                chk($sformatf("vec%0d parity bit", i), 32'(par), 32'(vt[i].exp_par));
        end

        // Back-to-back with valid held: 0x00 then 0xFF, one idle-high cycle between frames.
        chk("b2b ready", 32'(rdy[0]), 32'd1);
        dat[0] = 8'h00;
        vld[0] = 1'b1;
        @(negedge clk);
        run_frame(0, 8'h00, 8'hFF, 1'b0, 1'b1, done_at, par);
        chk("b2b first done position", 32'(done_at), 32'd40);
        @(negedge clk);
        vld[0] = 1'b0;
        run_frame(0, 8'hFF, 8'hFF, 1'b0, 1'b0, done_at, par);
        chk("b2b second done position", 32'(done_at), 32'd40);

        // One-cycle reset during data bit 3 abandons the frame without a done pulse.
        dat[0] = 8'h12;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre-reset line in bit 3", 32'({ser[0], bsy[0]}), 32'(2'b01));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after mid-frame reset", 32'({ser[0], bsy[0], rdy[0], dn[0]}), 32'(4'b1010));
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (dn[0] !== 1'b0 || ser[0] !== 1'b1 || bsy[0] !== 1'b0) bad++;
        end
        chk("abandoned frame stays idle, no done", 32'(bad), 32'd0);

        for (int r = 0; r < 24; r++) begin
            u   = int'($urandom_range(0, 3));
            b   = 8'($urandom_range(0, 255));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk($sformatf("rand%0d gap idle", r),
                    32'({ser[u], bsy[u], rdy[u], dn[u]}), 32'(4'b1010));
            end
            send(u, b, 8'($urandom), 1'b1, done_at, par);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

endmodule
